// File: rtl/matrix_mult_engine.sv
// Sequential N x N matrix engine: a single shared multiply/add unit, time-multiplexed by a
// small FSM, computes A*B, A+B, A-B or R+A*B into a result register read back over the bus.
module matrix_mult_engine #(
   parameter int N = 4,
   parameter int W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             RW,
   input  logic             matDecide,
   input  logic [1:0]       op,
   input  logic [N*N*W-1:0] dataInBus,
   output logic [N*N*W-1:0] dataOut,
   output logic             fleg,
   output logic             busy,
   output logic             err
);
   localparam int CW = $clog2(N);
   localparam logic [CW-1:0] LAST = CW'(N - 1);
   localparam logic [1:0] OP_MUL = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b10;
   localparam logic [1:0] OP_MAC = 2'b11;

   typedef enum logic [1:0] {IDLE, MUL, ELEM, DONE} StateT;

   StateT              state;
   logic [N*N*W-1:0]   matA;
   logic [N*N*W-1:0]   matB;
   logic [N*N*W-1:0]   matR;
   logic [1:0]         opReg;
   logic [CW-1:0]      rowIdx;
   logic [CW-1:0]      colIdx;
   logic [CW-1:0]      kIdx;
   logic [W-1:0]       acc;

   logic [W-1:0]       mulA;
   logic [W-1:0]       mulB;
   logic [W-1:0]       elemA;
   logic [W-1:0]       elemB;
   logic [W-1:0]       rOld;
   logic [W-1:0]       prod;
   logic [W-1:0]       accBase;
   logic [W-1:0]       macSum;
   logic [W-1:0]       elemRes;

   // Shared datapath; the self-determined W-bit multiply keeps only the low W product bits.
   always_comb begin
      mulA    = matA[(int'(rowIdx) * N + int'(kIdx)) * W +: W];
      mulB    = matB[(int'(kIdx) * N + int'(colIdx)) * W +: W];
      elemA   = matA[(int'(rowIdx) * N + int'(colIdx)) * W +: W];
      elemB   = matB[(int'(rowIdx) * N + int'(colIdx)) * W +: W];
      rOld    = matR[(int'(rowIdx) * N + int'(colIdx)) * W +: W];
      prod    = mulA * mulB;
      accBase = acc;
      if (kIdx == '0) begin
         accBase = (opReg == OP_MAC) ? rOld : '0;
      end
      macSum  = accBase + prod;
      elemRes = (opReg == OP_SUB) ? (elemA - elemB) : (elemA + elemB);
   end

   // Command decode, FSM sequencing and result write-back.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         matA    <= '0;
         matB    <= '0;
         matR    <= '0;
         dataOut <= '0;
         opReg   <= OP_MUL;
         rowIdx  <= '0;
         colIdx  <= '0;
         kIdx    <= '0;
         acc     <= '0;
         fleg    <= 1'b0;
         busy    <= 1'b0;
         err     <= 1'b0;
      end else begin
         fleg <= 1'b0;
         err  <= 1'b0;
         case (state)
            IDLE: begin
               if (enable) begin
                  if (RW && !matDecide) begin
                     matA <= dataInBus;
                     fleg <= 1'b1;
                  end else if (RW) begin
                     matB   <= dataInBus;
                     opReg  <= op;
                     busy   <= 1'b1;
                     rowIdx <= '0;
                     colIdx <= '0;
                     kIdx   <= '0;
                     state  <= (op == OP_MUL || op == OP_MAC) ? MUL : ELEM;
                  end else begin
                     dataOut <= matR;
                     fleg    <= 1'b1;
                  end
               end
            end
            MUL: begin
               if (enable) begin
                  err <= 1'b1;
               end
               if (kIdx == LAST) begin
                  matR[(int'(rowIdx) * N + int'(colIdx)) * W +: W] <= macSum;
                  kIdx <= '0;
                  if (colIdx == LAST) begin
                     colIdx <= '0;
                     if (rowIdx == LAST) begin
                        rowIdx <= '0;
                        state  <= DONE;
                     end else begin
                        rowIdx <= rowIdx + 1'b1;
                     end
                  end else begin
                     colIdx <= colIdx + 1'b1;
                  end
               end else begin
                  acc  <= macSum;
                  kIdx <= kIdx + 1'b1;
               end
            end
            ELEM: begin
               if (enable) begin
                  err <= 1'b1;
               end
               matR[(int'(rowIdx) * N + int'(colIdx)) * W +: W] <= elemRes;
               if (colIdx == LAST) begin
                  colIdx <= '0;
                  if (rowIdx == LAST) begin
                     rowIdx <= '0;
                     state  <= DONE;
                  end else begin
                     rowIdx <= rowIdx + 1'b1;
                  end
               end else begin
                  colIdx <= colIdx + 1'b1;
               end
            end
            DONE: begin
               // A command here is still dropped, but err stays low so it never overlaps fleg.
               fleg  <= 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_matrix_mult_engine.sv
// Scoreboard bench for matrix_mult_engine: a 4x4/16-bit and a 3x3/8-bit instance are driven
// with directed commands; monitors check every fleg against queued expected cycle and read data.
module tb_matrix_mult_engine;
   localparam int N4 = 4;
   localparam int W4 = 16;
   localparam int B4 = N4 * N4 * W4;
   localparam int N3 = 3;
   localparam int W3 = 8;
   localparam int B3 = N3 * N3 * W3;
   localparam logic [1:0] OPMUL = 2'b00;
   localparam logic [1:0] OPADD = 2'b01;
   localparam logic [1:0] OPSUB = 2'b10;
   localparam logic [1:0] OPMAC = 2'b11;

   typedef struct {
      int           expCyc;
      bit           isRead;
      logic [255:0] expData;
      int           tag;
   } ExpEntry;

   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;

   logic          en4, rw4, md4, fleg4, busy4, err4;
   logic [1:0]    op4;
   logic [B4-1:0] din4, dout4;
   logic          en3, rw3, md3, fleg3, busy3, err3;
   logic [1:0]    op3;
   logic [B3-1:0] din3, dout3;

   ExpEntry q4[$];
   ExpEntry q3[$];
   ExpEntry e4, e3;
   int vectors = 0;
   int miscompares = 0;
   int errCnt4 = 0;
   int errCnt3 = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   matrix_mult_engine #(.N(N4), .W(W4)) dut4 (
      .clk(clk), .rst(rst), .enable(en4), .RW(rw4), .matDecide(md4), .op(op4),
      .dataInBus(din4), .dataOut(dout4), .fleg(fleg4), .busy(busy4), .err(err4)
   );

   matrix_mult_engine #(.N(N3), .W(W3)) dut3 (
      .clk(clk), .rst(rst), .enable(en3), .RW(rw3), .matDecide(md3), .op(op3),
      .dataInBus(din3), .dataOut(dout3), .fleg(fleg3), .busy(busy3), .err(err3)
   );

   task automatic checkOutput(input string what, input int tag, input logic [255:0] act,
                              input logic [255:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s (tag %0d): got %0h, expected %0h", what, tag, act, exp);
      end
   endtask

   function automatic logic [255:0] fillMat(input int n, input int w, input int v);
      logic [255:0] m = '0;
      for (int e = 0; e < n * n; e++)
         for (int b = 0; b < w; b++)
            m[e * w + b] = v[b];
      return m;
   endfunction

   function automatic logic [255:0] setEl(input logic [255:0] m, input int n, input int w,
                                          input int i, input int j, input int v);
      logic [255:0] r = m;
      for (int b = 0; b < w; b++)
         r[(i * n + j) * w + b] = v[b];
      return r;
   endfunction

   // Drive one command for one edge; queue the expected fleg (cycle seen after that edge + lat).
   task automatic applyStimulus(input int dut, input logic rwIn, input logic mdIn,
                                input logic [1:0] opIn, input logic [255:0] dataIn,
                                input bit expectFleg, input int lat,
                                input logic [255:0] expData, input int tag);
      ExpEntry ent;
      @(negedge clk);
      ent = '{expCyc: cyc + 1 + lat, isRead: !rwIn, expData: expData, tag: tag};
      if (dut == 4) begin
         en4 = 1'b1; rw4 = rwIn; md4 = mdIn; op4 = opIn; din4 = dataIn[B4-1:0];
         if (expectFleg) q4.push_back(ent);
      end else begin
         en3 = 1'b1; rw3 = rwIn; md3 = mdIn; op3 = opIn; din3 = dataIn[B3-1:0];
         if (expectFleg) q3.push_back(ent);
      end
      @(posedge clk);
      #1;
      en4 = 1'b0;
      en3 = 1'b0;
   endtask

   task automatic waitIdle(input int dut, input int maxc, input int tag);
      int n = 0;
      while (((dut == 4) ? busy4 : busy3) && n < maxc) begin
         @(posedge clk);
         #1;
         n++;
      end
      checkOutput("idleTimeout", tag, (dut == 4) ? busy4 : busy3, 1'b0);
   endtask

   always @(posedge clk) begin
      #1;
      if (err4) errCnt4++;
      if (fleg4) begin
         checkOutput("flegErrOverlap4", cyc, err4, 1'b0);
         if (q4.size() == 0) begin
            checkOutput("unexpectedFleg4", cyc, fleg4, 1'b0);
         end else begin
            e4 = q4.pop_front();
            checkOutput("flegCycle4", e4.tag, cyc, e4.expCyc);
            if (e4.isRead) checkOutput("readData4", e4.tag, dout4, e4.expData);
         end
      end
   end

   always @(posedge clk) begin
      #1;
      if (err3) errCnt3++;
      if (fleg3) begin
         checkOutput("flegErrOverlap3", cyc, err3, 1'b0);
         if (q3.size() == 0) begin
            checkOutput("unexpectedFleg3", cyc, fleg3, 1'b0);
         end else begin
            e3 = q3.pop_front();
            checkOutput("flegCycle3", e3.tag, cyc, e3.expCyc);
            if (e3.isRead) checkOutput("readData3", e3.tag, dout3, e3.expData);
         end
      end
   end

   initial begin
      #300000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [255:0] ident, seq, ovfA, ovfB, ovfR, a3, b3, r3;
      int errBase;
      en4 = 0; rw4 = 0; md4 = 0; op4 = OPMUL; din4 = '0;
      en3 = 0; rw3 = 0; md3 = 0; op3 = OPMUL; din3 = '0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      checkOutput("resetBusy4", 0, busy4, 1'b0);
      checkOutput("resetFleg4", 0, fleg4, 1'b0);
      checkOutput("resetErr4", 0, err4, 1'b0);
      checkOutput("resetDout4", 0, dout4, '0);
      checkOutput("resetDout3", 0, dout3, '0);
      applyStimulus(4, 0, 0, OPMUL, '0, 1, 0, '0, 1);
      applyStimulus(3, 0, 0, OPMUL, '0, 1, 0, '0, 2);

      // Identity times 1..16
      ident = '0;
      for (int i = 0; i < 4; i++) ident = setEl(ident, 4, 16, i, i, 1);
      seq = '0;
      for (int e = 0; e < 16; e++) seq = setEl(seq, 4, 16, e / 4, e % 4, e + 1);
      applyStimulus(4, 1, 0, OPMUL, ident, 1, 0, '0, 3);
      applyStimulus(4, 1, 1, OPMUL, seq, 1, 65, '0, 4);
      waitIdle(4, 80, 4);
      applyStimulus(4, 0, 0, OPMUL, '0, 1, 0, seq, 5);

      // Constant fill: MUL, MUL again, then MAC on top
      applyStimulus(4, 1, 0, OPMUL, fillMat(4, 16, 2), 1, 0, '0, 6);
      applyStimulus(4, 1, 1, OPMUL, fillMat(4, 16, 3), 1, 65, '0, 7);
      waitIdle(4, 80, 7);
      applyStimulus(4, 0, 0, OPMUL, '0, 1, 0, fillMat(4, 16, 'h18), 8);
      applyStimulus(4, 1, 1, OPMUL, fillMat(4, 16, 3), 1, 65, '0, 9);
      waitIdle(4, 80, 9);
      applyStimulus(4, 0, 0, OPMUL, '0, 1, 0, fillMat(4, 16, 'h18), 10);
      applyStimulus(4, 1, 1, OPMAC, fillMat(4, 16, 3), 1, 65, '0, 11);
      waitIdle(4, 80, 11);
      applyStimulus(4, 0, 0, OPMUL, '0, 1, 0, fillMat(4, 16, 'h30), 12);

      // SUB wraps below zero, ADD reuses the same operands
      applyStimulus(4, 1, 0, OPMUL, fillMat(4, 16, 0), 1, 0, '0, 13);
      applyStimulus(4, 1, 1, OPSUB, fillMat(4, 16, 1), 1, 17, '0, 14);
      waitIdle(4, 30, 14);
      applyStimulus(4, 0, 0, OPMUL, '0, 1, 0, fillMat(4, 16, 'hFFFF), 15);
      applyStimulus(4, 1, 1, OPADD, fillMat(4, 16, 1), 1, 17, '0, 16);
      waitIdle(4, 30, 16);
      applyStimulus(4, 0, 0, OPMUL, '0, 1, 0, fillMat(4, 16, 1), 17);

      // Overflow: 0x100*0x100 + 1*5 truncates to 0x0005
      ovfA = setEl(setEl('0, 4, 16, 0, 0, 'h100), 4, 16, 0, 1, 1);
      ovfB = setEl(setEl('0, 4, 16, 0, 0, 'h100), 4, 16, 1, 0, 5);
      ovfR = setEl('0, 4, 16, 0, 0, 5);
      applyStimulus(4, 1, 0, OPMUL, ovfA, 1, 0, '0, 18);
      applyStimulus(4, 1, 1, OPMUL, ovfB, 1, 65, '0, 19);
      waitIdle(4, 80, 19);
      applyStimulus(4, 0, 0, OPMUL, '0, 1, 0, ovfR, 20);

      // Commands during MUL are rejected with err and leave the operation untouched
      applyStimulus(4, 1, 0, OPMUL, fillMat(4, 16, 1), 1, 0, '0, 21);
      applyStimulus(4, 1, 1, OPMUL, fillMat(4, 16, 4), 1, 65, '0, 22);
      repeat (4) @(posedge clk);
      errBase = errCnt4;
      applyStimulus(4, 1, 0, OPMUL, fillMat(4, 16, 7), 0, 0, '0, 23);
      applyStimulus(4, 1, 1, OPADD, fillMat(4, 16, 9), 0, 0, '0, 24);
      applyStimulus(4, 0, 0, OPMUL, '0, 0, 0, '0, 25);
      repeat (2) @(posedge clk);
      #2;
      checkOutput("rejectErrCount", 25, errCnt4 - errBase, 3);
      checkOutput("rejectBusyHeld", 25, busy4, 1'b1);
      checkOutput("rejectDoutHeld", 25, dout4, ovfR);
      waitIdle(4, 80, 22);
      applyStimulus(4, 0, 0, OPMUL, '0, 1, 0, fillMat(4, 16, 'h10), 26);

      // Reset 10 cycles into MUL: no fleg, result cleared
      applyStimulus(4, 1, 1, OPMUL, fillMat(4, 16, 4), 0, 0, '0, 27);
      repeat (10) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      checkOutput("midResetBusy4", 27, busy4, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      repeat (80) @(posedge clk);
      applyStimulus(4, 0, 0, OPMUL, '0, 1, 0, '0, 28);

      // N=3, W=8 packing: A = 1..9, B = diag(1,2,3)
      a3 = '0;
      for (int e = 0; e < 9; e++) a3 = setEl(a3, 3, 8, e / 3, e % 3, e + 1);
      b3 = setEl(setEl(setEl('0, 3, 8, 0, 0, 1), 3, 8, 1, 1, 2), 3, 8, 2, 2, 3);
      r3 = '0;
      r3 = setEl(r3, 3, 8, 0, 0, 1);  r3 = setEl(r3, 3, 8, 0, 1, 4);  r3 = setEl(r3, 3, 8, 0, 2, 9);
      r3 = setEl(r3, 3, 8, 1, 0, 4);  r3 = setEl(r3, 3, 8, 1, 1, 10); r3 = setEl(r3, 3, 8, 1, 2, 18);
      r3 = setEl(r3, 3, 8, 2, 0, 7);  r3 = setEl(r3, 3, 8, 2, 1, 16); r3 = setEl(r3, 3, 8, 2, 2, 27);
      applyStimulus(3, 1, 0, OPMUL, a3, 1, 0, '0, 30);
      applyStimulus(3, 1, 1, OPMUL, b3, 1, 28, '0, 31);
      waitIdle(3, 40, 31);
      applyStimulus(3, 0, 0, OPMUL, '0, 1, 0, r3, 32);

      applyStimulus(3, 1, 1, OPMUL, b3, 0, 0, '0, 33);
      repeat (10) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      checkOutput("midResetBusy3", 33, busy3, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      repeat (40) @(posedge clk);
      applyStimulus(3, 0, 0, OPMUL, '0, 1, 0, '0, 34);

      repeat (3) @(posedge clk);
      #2;
      checkOutput("pendingFleg4", 0, q4.size(), 0);
      checkOutput("pendingFleg3", 0, q3.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
